// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver and branch history table:
// branch-type encodings, 2-bit counter type/constants and the counter update rule.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_EQ   = 3'b100,
    BR_NE   = 3'b101,
    BR_LT   = 3'b110,
    BR_GE   = 3'b111
  } branch_e;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'd0;
  localparam cnt_t CNT_WNT = 2'd1;
  localparam cnt_t CNT_WT  = 2'd2;
  localparam cnt_t CNT_ST  = 2'd3;

  function automatic cnt_t cnt_next(input cnt_t cnt, input logic up);
    if (up) return (cnt == CNT_ST)  ? CNT_ST  : cnt_t'(cnt + 2'd1);
    else    return (cnt == CNT_SNT) ? CNT_SNT : cnt_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational RV32I branch/jump condition decoder producing the next-PC selects.
module branch_resolve
  import branch_pkg::*;
(
  input  logic [2:0] branch,
  input  logic       zero,
  input  logic       less,
  output logic       pcAsrc,
  output logic       pcBsrc
);

  // NOTE: every output gets a default before the case, so codes that match no
  // arm (e.g. 3'b011) still drive a value and no latch is inferred.
  always_comb begin
    pcAsrc = 1'b0;
    pcBsrc = 1'b0;
    case (branch)
      BR_JAL:  pcAsrc = 1'b1;
      BR_JALR: begin
        pcAsrc = 1'b1;
        pcBsrc = 1'b1;
      end
      BR_EQ:   pcAsrc = zero;
      BR_NE:   pcAsrc = !zero;
      BR_LT:   pcAsrc = less;
      BR_GE:   pcAsrc = !less;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predict.sv
// Branch resolver plus PC-indexed table of 2-bit saturating counters with a
// registered mispredict pulse. Define BRANCH_PREDICT_STATS_EN to add br_count/miss_count.
module branch_predict
  import branch_pkg::*;
#(
  parameter int   XLEN     = 32,
  parameter int   IDX_W    = 6,
  parameter cnt_t INIT_CNT = CNT_WNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      branch,
  input  logic            zero,
  input  logic            less,
  input  logic            ex_pred_taken,
  output logic            pcAsrc,
  output logic            pcBsrc,
  output logic            mispredict,
  output logic            mispredict_taken
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  cnt_t             bht [DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond;
  logic             taken;
  logic             miss_next;

  branch_resolve u_resolve (
    .branch (branch),
    .zero   (zero),
    .less   (less),
    .pcAsrc (pcAsrc),
    .pcBsrc (pcBsrc)
  );

  assign fetch_idx  = fetch_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign pred_taken = bht[fetch_idx][1];

  assign cond      = ex_valid & branch[2];
  assign taken     = pcAsrc;
  assign miss_next = cond & (taken != ex_pred_taken);

  // Tag bits and byte offset do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // NOTE: the table is a flop array rather than a RAM precisely so that every
  // entry can be forced to INIT_CNT by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= INIT_CNT;
      mispredict       <= 1'b0;
      mispredict_taken <= 1'b0;
    end else begin
      if (cond) bht[ex_idx] <= cnt_next(bht[ex_idx], taken);
      mispredict       <= miss_next;
      mispredict_taken <= miss_next & taken;
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count   <= '0;
      miss_count <= '0;
    end else begin
      if (cond)      br_count   <= br_count + 32'd1;
      if (miss_next) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict.sv
// Self-checking bench for branch_predict: directed scenarios plus random traffic,
// registered outputs checked through an expectation queue drained by a monitor.
module tb_branch_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  branch;
  logic        zero;
  logic        less;
  logic        ex_pred_taken;
  logic        pcAsrc;
  logic        pcBsrc;
  logic        mispredict;
  logic        mispredict_taken;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] br_count;
  logic [31:0] miss_count;
`endif

  branch_predict dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .branch           (branch),
    .zero             (zero),
    .less             (less),
    .ex_pred_taken    (ex_pred_taken),
    .pcAsrc           (pcAsrc),
    .pcBsrc           (pcBsrc),
    .mispredict       (mispredict),
    .mispredict_taken (mispredict_taken)
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    .br_count         (br_count),
    .miss_count       (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: counters as plain integers, 64 entries indexed by word address.
  int          model_cnt [64];
  int unsigned model_br   = 0;
  int unsigned model_miss = 0;
  logic [1:0]  exp_q [$];   // {mispredict, mispredict_taken} for the next edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_cnt[i] = 1;
    model_br   = 0;
    model_miss = 0;
  endtask

  // One execute/fetch cycle: drive on the falling edge, check combinational
  // outputs before the rising edge, queue the registered expectation.
  task automatic step(input logic [31:0] f_pc, input logic v, input logic [31:0] e_pc,
                      input logic [2:0] br, input logic z, input logic l, input logic ep);
    logic ea, eb, c, mis;
    @(negedge clk);
    fetch_pc = f_pc; ex_valid = v; ex_pc = e_pc; branch = br;
    zero = z; less = l; ex_pred_taken = ep;
    #1;
    ea = 1'b0; eb = 1'b0;
    case (br)
      3'b001: ea = 1'b1;
      3'b010: begin ea = 1'b1; eb = 1'b1; end
      3'b100: ea = z;
      3'b101: ea = !z;
      3'b110: ea = l;
      3'b111: ea = !l;
      default: ;
    endcase
    check("pcAsrc", {31'd0, pcAsrc}, {31'd0, ea});
    check("pcBsrc", {31'd0, pcBsrc}, {31'd0, eb});
    check("pred_taken", {31'd0, pred_taken}, {31'd0, model_cnt[idx_of(f_pc)] >= 2});
    c   = v && br[2];
    mis = c && (ea != ep);
    exp_q.push_back({mis, mis && ea});
    if (c) begin
      if (ea) model_cnt[idx_of(e_pc)] = (model_cnt[idx_of(e_pc)] == 3) ? 3 : model_cnt[idx_of(e_pc)] + 1;
      else    model_cnt[idx_of(e_pc)] = (model_cnt[idx_of(e_pc)] == 0) ? 0 : model_cnt[idx_of(e_pc)] - 1;
      model_br++;
    end
    if (mis) model_miss++;
  endtask

  task automatic idle();
    step(32'h0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_pred(input logic [31:0] pc);
    step(pc, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: after every rising edge, compare the registered outputs against
  // the oldest queued expectation (no expectation means the outputs must be idle).
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        continue;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      check("mispredict", {31'd0, mispredict}, {31'd0, e[1]});
      check("mispredict_taken", {31'd0, mispredict_taken}, {31'd0, e[0]});
    end
  end

  initial begin
    rst = 1'b1;
    fetch_pc = '0; ex_valid = 1'b0; ex_pc = '0; branch = '0;
    zero = 1'b0; less = 1'b0; ex_pred_taken = 1'b0;
    model_reset();

    // Reset defaults
    repeat (2) @(posedge clk);
    #2;
    foreach (exp_q[i]) exp_q.delete(i);
    fetch_pc = 32'h0;  #1; check("rst_pred_0x0",  {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h4;  #1; check("rst_pred_0x4",  {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'hFC; #1; check("rst_pred_0xFC", {31'd0, pred_taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Training at 0x40, then aliased lookup at 0x140
    step(32'h0, 1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0);
    step(32'h40, 1'b1, 32'h40, 3'b100, 1'b1, 1'b0, 1'b0);
    check_pred(32'h40);
    check_pred(32'h140);
    check("train_cnt_0x40", model_cnt[idx_of(32'h40)], 32'd3);

    // Saturation at 0x80: five taken, one not-taken
    repeat (5) step(32'h80, 1'b1, 32'h80, 3'b110, 1'b0, 1'b1, 1'b1);
    step(32'h80, 1'b1, 32'h80, 3'b110, 1'b0, 1'b0, 1'b1);
    check_pred(32'h80);

    // Jump, bubble and illegal code leave the table alone
    step(32'h80, 1'b1, 32'h80, 3'b010, 1'b0, 1'b0, 1'b0);
    step(32'h80, 1'b0, 32'h80, 3'b100, 1'b0, 1'b0, 1'b1);
    step(32'h80, 1'b1, 32'h80, 3'b011, 1'b1, 1'b1, 1'b1);
    check_pred(32'h80);
    step(32'hC0, 1'b1, 32'hC0, 3'b001, 1'b0, 1'b0, 1'b1);
    check_pred(32'hC0);
    idle();

`ifdef BRANCH_PREDICT_STATS_EN
    @(negedge clk);
    check("br_count", br_count, model_br);
    check("miss_count", miss_count, model_miss);
`endif

    // Mid-operation reset right after a mispredicting resolve
    step(32'h0, 1'b1, 32'h80, 3'b101, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    ex_valid = 1'b0; branch = 3'b000;
    #1;
    check("midrst_mispredict", {31'd0, mispredict}, 32'd0);
    check("midrst_mispredict_taken", {31'd0, mispredict_taken}, 32'd0);
    model_reset();
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i * 4);
      #0.1;
      if (pred_taken !== 1'b0) check("midrst_pred", {31'd0, pred_taken}, 32'd0);
    end
    fetch_pc = 32'h40; #1; check("midrst_pred_0x40", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h80; #1; check("midrst_pred_0x80", {31'd0, pred_taken}, 32'd0);
`ifdef BRANCH_PREDICT_STATS_EN
    check("rst_br_count", br_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // First edge after release: one taken update moves 0x80 from 1 to 2
    step(32'h80, 1'b1, 32'h80, 3'b100, 1'b1, 1'b0, 1'b0);
    check_pred(32'h80);

    // Random traffic over a handful of aliasing PCs
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fp, ep;
      fp = {$urandom_range(0, 3) << 8} | ($urandom_range(0, 7) << 2);
      ep = {$urandom_range(0, 3) << 8} | ($urandom_range(0, 7) << 2);
      step(fp, ($urandom_range(0, 9) < 8), ep, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 1) == 1) ? 1'($urandom) : (model_cnt[idx_of(ep)] >= 2));
    end
    idle();
    idle();

`ifdef BRANCH_PREDICT_STATS_EN
    @(negedge clk);
    check("final_br_count", br_count, model_br);
    check("final_miss_count", miss_count, model_miss);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
